// File: rtl/bru_q.sv
// bru_q: branch resolve unit with prediction check, per-entry flush and an in-order result queue
module bru_q #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int BID_W    = 4,
  parameter int OP_W     = 5,
  parameter int RD_W     = 5,
  parameter int ETW_W    = 8,
  parameter int ADEL_BIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [OP_W-1:0]  s_op,
  input  logic [XLEN-1:0]  s_a,
  input  logic [XLEN-1:0]  s_b,
  input  logic [XLEN-1:0]  s_pc,
  input  logic [25:0]      s_offset,
  input  logic [RD_W-1:0]  s_rd,
  input  logic             s_pred_taken,
  input  logic [XLEN-1:0]  s_pred_target,
  input  logic             s_is_delayslot,
  input  logic [BID_W-1:0] s_branch_id,
  input  logic [ETW_W-1:0] s_etw,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [XLEN-1:0]  m_target,
  output logic             m_taken,
  output logic             m_mispredict,
  output logic [XLEN-1:0]  m_val,
  output logic [RD_W-1:0]  m_rd,
  output logic             m_rd_wen,
  output logic [XLEN-1:0]  m_pc,
  output logic             m_is_delayslot,
  output logic [BID_W-1:0] m_branch_id,
  output logic [ETW_W-1:0] m_etw,
  input  logic             flush_valid,
  input  logic             flush_kind,
  input  logic [BID_W-1:0] flush_branch_id,
  output logic             fwd_valid,
  output logic [XLEN-1:0]  fwd_val,
  output logic [RD_W-1:0]  fwd_rd,
  output logic [3:0]       fwd_byte_wen
);
  localparam logic [OP_W-1:0] FU_OP_BRU_J      = OP_W'(0);
  localparam logic [OP_W-1:0] FU_OP_BRU_JAL    = OP_W'(1);
  localparam logic [OP_W-1:0] FU_OP_BRU_JR     = OP_W'(2);
  localparam logic [OP_W-1:0] FU_OP_BRU_JALR   = OP_W'(3);
  localparam logic [OP_W-1:0] FU_OP_BRU_ERET   = OP_W'(4);
  localparam logic [OP_W-1:0] FU_OP_BRU_BEQ    = OP_W'(5);
  localparam logic [OP_W-1:0] FU_OP_BRU_BNE    = OP_W'(6);
  localparam logic [OP_W-1:0] FU_OP_BRU_BGEZ   = OP_W'(7);
  localparam logic [OP_W-1:0] FU_OP_BRU_BGEZAL = OP_W'(8);
  localparam logic [OP_W-1:0] FU_OP_BRU_BGTZ   = OP_W'(9);
  localparam logic [OP_W-1:0] FU_OP_BRU_BLEZ   = OP_W'(10);
  localparam logic [OP_W-1:0] FU_OP_BRU_BLTZ   = OP_W'(11);
  localparam logic [OP_W-1:0] FU_OP_BRU_BLTZAL = OP_W'(12);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  ptgt;
    logic [25:0]      off;
    logic [RD_W-1:0]  rd;
    logic             pt;
    logic             ds;
    logic [BID_W-1:0] bid;
    logic [ETW_W-1:0] etw;
  } stg_t;

  typedef struct packed {
    logic [XLEN-1:0]  tgt;
    logic [XLEN-1:0]  val;
    logic [XLEN-1:0]  pc;
    logic             tkn;
    logic             mis;
    logic             wen;
    logic             ds;
    logic [RD_W-1:0]  rd;
    logic [BID_W-1:0] bid;
    logic [ETW_W-1:0] etw;
  } ent_t;

  stg_t             stg_q;
  logic             stg_v_q, stg_v_d;
  ent_t             q_mem_q [DEPTH];
  logic [DEPTH-1:0] q_v_q, q_v_d, q_kill;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_kill, stg_kill, enq, deq, acc;
  logic [XLEN-1:0]  br_tgt;
  ent_t             res, hd, mo;

  assign s_kill   = flush_valid & (!flush_kind | (s_branch_id == flush_branch_id & !s_is_delayslot));
  assign stg_kill = stg_v_q & flush_valid & (!flush_kind | (stg_q.bid == flush_branch_id & !stg_q.ds));
  for (genvar i = 0; i < DEPTH; i++) begin : g_kill
    assign q_kill[i] = flush_valid & (!flush_kind | (q_mem_q[i].bid == flush_branch_id & !q_mem_q[i].ds));
  end

  assign br_tgt = stg_q.pc + XLEN'(4) + {{(XLEN-18){stg_q.off[15]}}, stg_q.off[15:0], 2'b00};

  always_comb begin
    res     = '0;
    res.val = stg_q.pc + XLEN'(8);
    res.pc  = stg_q.pc;
    res.rd  = stg_q.rd;
    res.ds  = stg_q.ds;
    res.bid = stg_q.bid;
    case (stg_q.op)
      FU_OP_BRU_J, FU_OP_BRU_JAL: begin
        res.tgt = {stg_q.pc[XLEN-1:28], stg_q.off, 2'b00};
        res.tkn = 1'b1;
      end
      FU_OP_BRU_JR, FU_OP_BRU_JALR, FU_OP_BRU_ERET: begin
        res.tgt = stg_q.a;
        res.tkn = 1'b1;
      end
      FU_OP_BRU_BEQ:                     begin res.tgt = br_tgt; res.tkn = stg_q.a == stg_q.b; end
      FU_OP_BRU_BNE:                     begin res.tgt = br_tgt; res.tkn = stg_q.a != stg_q.b; end
      FU_OP_BRU_BGEZ, FU_OP_BRU_BGEZAL: begin res.tgt = br_tgt; res.tkn = !stg_q.a[XLEN-1]; end
      FU_OP_BRU_BGTZ:                    begin res.tgt = br_tgt; res.tkn = !stg_q.a[XLEN-1] & (stg_q.a != '0); end
      FU_OP_BRU_BLEZ:                    begin res.tgt = br_tgt; res.tkn = stg_q.a[XLEN-1] | (stg_q.a == '0); end
      FU_OP_BRU_BLTZ, FU_OP_BRU_BLTZAL: begin res.tgt = br_tgt; res.tkn = stg_q.a[XLEN-1]; end
      default: ;
    endcase
    res.wen = stg_q.op inside {FU_OP_BRU_JAL, FU_OP_BRU_JALR, FU_OP_BRU_BGEZAL, FU_OP_BRU_BLTZAL};
    res.mis = (res.tkn != stg_q.pt) | (res.tkn & (res.tgt != stg_q.ptgt));
    res.etw = stg_q.etw | (ETW_W'(res.tkn & (res.tgt[1:0] != 2'b00)) << ADEL_BIT);
  end

  // a killed head slot is never presented, so it cannot handshake on the cycle it dies
  assign hd      = q_mem_q[head_q];
  assign m_valid = q_v_q[head_q] & !q_kill[head_q];
  assign deq     = (m_valid & m_ready) | ((cnt_q != '0) & !q_v_q[head_q]);
  assign enq     = stg_v_q & !stg_kill & ((cnt_q < CW'(DEPTH)) | (m_valid & m_ready));
  assign s_ready = !stg_v_q | enq;
  assign acc     = s_valid & s_ready & !s_kill;
  assign stg_v_d = acc | (stg_v_q & !enq & !stg_kill);
  assign head_d  = deq ? head_q + AW'(1) : head_q;
  assign tail_d  = enq ? tail_q + AW'(1) : tail_q;
  assign cnt_d   = cnt_q + CW'(enq) - CW'(deq);

  always_comb begin
    q_v_d = q_v_q & ~q_kill;
    if (deq) q_v_d[head_q] = 1'b0;
    if (enq) q_v_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_v_q <= 1'b0;
      q_v_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      stg_v_q <= stg_v_d;
      q_v_q   <= q_v_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) stg_q <= '{op: s_op, a: s_a, b: s_b, pc: s_pc, ptgt: s_pred_target, off: s_offset,
                        rd: s_rd, pt: s_pred_taken, ds: s_is_delayslot, bid: s_branch_id, etw: s_etw};
    if (enq) q_mem_q[tail_q] <= res;
  end

  assign mo             = m_valid ? hd : '0;
  assign m_target       = mo.tgt;
  assign m_taken        = mo.tkn;
  assign m_mispredict   = mo.mis;
  assign m_val          = mo.val;
  assign m_rd           = mo.rd;
  assign m_rd_wen       = mo.wen;
  assign m_pc           = mo.pc;
  assign m_is_delayslot = mo.ds;
  assign m_branch_id    = mo.bid;
  assign m_etw          = mo.etw;

  assign fwd_valid    = stg_v_q & !stg_kill;
  assign fwd_val      = fwd_valid ? res.val : '0;
  assign fwd_rd       = fwd_valid ? res.rd : '0;
  assign fwd_byte_wen = {4{fwd_valid & res.wen}};
endmodule

// File: tb/tb_bru_q.sv
// tb_bru_q: directed checks of resolve, queueing, flush and reset behaviour of bru_q
module tb_bru_q;
  localparam int DEPTH = 4;
  localparam logic [4:0] OP_J = 5'd0, OP_JAL = 5'd1, OP_JALR = 5'd3, OP_ERET = 5'd4,
                         OP_BEQ = 5'd5, OP_BNE = 5'd6, OP_BGEZ = 5'd7, OP_BGTZ = 5'd9,
                         OP_BLEZ = 5'd10, OP_BLTZAL = 5'd12, OP_UNDEF = 5'd31;

  logic        clk = 1'b0, rst = 1'b1;
  logic        s_valid = 1'b0, s_ready;
  logic [4:0]  s_op = '0;
  logic [31:0] s_a = '0, s_b = '0, s_pc = '0, s_pred_target = '0;
  logic [25:0] s_offset = '0;
  logic [4:0]  s_rd = '0;
  logic        s_pred_taken = 1'b0, s_is_delayslot = 1'b0;
  logic [3:0]  s_branch_id = '0;
  logic [7:0]  s_etw = '0;
  logic        m_valid, m_ready = 1'b0, m_taken, m_mispredict, m_rd_wen, m_is_delayslot;
  logic [31:0] m_target, m_val, m_pc;
  logic [4:0]  m_rd;
  logic [3:0]  m_branch_id;
  logic [7:0]  m_etw;
  logic        flush_valid = 1'b0, flush_kind = 1'b0;
  logic [3:0]  flush_branch_id = '0;
  logic        fwd_valid;
  logic [31:0] fwd_val;
  logic [4:0]  fwd_rd;
  logic [3:0]  fwd_byte_wen;
  int          checks = 0, errors = 0;
  logic [3:0]  ids [4] = '{4'd3, 4'd4, 4'd4, 4'd4};

  bru_q #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_a(s_a), .s_b(s_b),
    .s_pc(s_pc), .s_offset(s_offset), .s_rd(s_rd), .s_pred_taken(s_pred_taken),
    .s_pred_target(s_pred_target), .s_is_delayslot(s_is_delayslot), .s_branch_id(s_branch_id),
    .s_etw(s_etw), .m_valid(m_valid), .m_ready(m_ready), .m_target(m_target), .m_taken(m_taken),
    .m_mispredict(m_mispredict), .m_val(m_val), .m_rd(m_rd), .m_rd_wen(m_rd_wen), .m_pc(m_pc),
    .m_is_delayslot(m_is_delayslot), .m_branch_id(m_branch_id), .m_etw(m_etw),
    .flush_valid(flush_valid), .flush_kind(flush_kind), .flush_branch_id(flush_branch_id),
    .fwd_valid(fwd_valid), .fwd_val(fwd_val), .fwd_rd(fwd_rd), .fwd_byte_wen(fwd_byte_wen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [25:0] off, input logic pt,
                       input logic [31:0] ptgt, input logic [3:0] bid, input logic ds,
                       input logic [7:0] etw);
    s_valid = 1'b1; s_op = op; s_a = a; s_b = b; s_pc = pc; s_offset = off; s_rd = 5'd31;
    s_pred_taken = pt; s_pred_target = ptgt; s_branch_id = bid; s_is_delayslot = ds; s_etw = etw;
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [25:0] off, input logic pt,
                        input logic [31:0] ptgt, input logic [7:0] etw, input logic [31:0] e_tgt,
                        input logic e_tkn, input logic e_mis, input logic e_wen, input logic [7:0] e_etw);
    m_ready = 1'b0;
    drive(op, a, b, pc, off, pt, ptgt, 4'd0, 1'b0, etw);
    #1 chk("s_ready_idle", s_ready, 1);
    tick;
    s_valid = 1'b0;
    #1 chk("m_valid_stage", m_valid, 0);
    chk("fwd_valid", fwd_valid, 1);
    chk("fwd_val", fwd_val, pc + 32'd8);
    chk("fwd_rd", fwd_rd, 31);
    chk("fwd_byte_wen", fwd_byte_wen, {4{e_wen}});
    tick;
    chk("m_valid", m_valid, 1);
    chk("m_target", m_target, e_tgt);
    chk("m_taken", m_taken, e_tkn);
    chk("m_mispredict", m_mispredict, e_mis);
    chk("m_rd_wen", m_rd_wen, e_wen);
    chk("m_val", m_val, pc + 32'd8);
    chk("m_rd", m_rd, 31);
    chk("m_pc", m_pc, pc);
    chk("m_etw", m_etw, e_etw);
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    chk("m_valid_drained", m_valid, 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #10;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_m_target", m_target, 0);
    chk("rst_fwd_val", fwd_val, 0);
    @(negedge clk) rst = 1'b1;
    tick;

    run_op(OP_BEQ, 32'd5, 32'd5, 32'h1000, 26'h3, 1'b1, 32'h1010, 8'h00, 32'h1010, 1, 0, 0, 8'h00);
    run_op(OP_JALR, 32'h2002, 32'h0, 32'h3000, 26'h0, 1'b1, 32'h2002, 8'h00, 32'h2002, 1, 0, 1, 8'h01);
    run_op(OP_J, 32'h0, 32'h0, 32'hA000_0000, 26'h0123456, 1'b0, 32'h0, 8'h00, 32'hA048_D158, 1, 1, 0, 8'h00);
    run_op(OP_BLTZAL, 32'hFFFF_FFFF, 32'h0, 32'h4000, 26'hFFFF, 1'b1, 32'h4000, 8'h00, 32'h4000, 1, 0, 1, 8'h00);
    run_op(OP_BNE, 32'd7, 32'd7, 32'h5000, 26'h10, 1'b0, 32'h0, 8'h00, 32'h5044, 0, 0, 0, 8'h00);
    run_op(OP_BLEZ, 32'h0, 32'h0, 32'h6000, 26'h1, 1'b1, 32'h6000, 8'h00, 32'h6008, 1, 1, 0, 8'h00);
    run_op(OP_UNDEF, 32'h1234, 32'h1234, 32'h6100, 26'h1, 1'b1, 32'h0, 8'h00, 32'h0, 0, 1, 0, 8'h00);
    run_op(OP_BGTZ, 32'h8000_0000, 32'h0, 32'h7000, 26'h2, 1'b1, 32'h700C, 8'h00, 32'h700C, 0, 1, 0, 8'h00);
    run_op(OP_BGEZ, 32'h0, 32'h0, 32'h8000, 26'h0, 1'b1, 32'h8004, 8'h80, 32'h8004, 1, 0, 0, 8'h80);
    run_op(OP_JAL, 32'h0, 32'h0, 32'h0, 26'h1, 1'b1, 32'h4, 8'h00, 32'h4, 1, 0, 1, 8'h00);
    run_op(OP_ERET, 32'h9001, 32'h0, 32'h9000, 26'h0, 1'b1, 32'h9001, 8'h00, 32'h9001, 1, 0, 0, 8'h01);

    // fill queue plus stage, then drain in order across pointer wrap
    m_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      drive(OP_BNE, 32'd1, 32'd2, 32'h100 * (i + 1), 26'h0, 1'b1, 32'h100 * (i + 1) + 4, 4'd0, 1'b0, 8'h00);
      #1 chk("fill_s_ready", s_ready, 1);
      tick;
    end
    s_valid = 1'b0;
    #1 chk("full_s_ready", s_ready, 0);
    chk("full_head_pc", m_pc, 32'h100);
    m_ready = 1'b1;
    #1 chk("full_deq_s_ready", s_ready, 1);
    for (int i = 0; i <= DEPTH; i++) begin
      chk("drain_m_valid", m_valid, 1);
      chk("drain_m_pc", m_pc, 32'h100 * (i + 1));
      chk("drain_m_target", m_target, 32'h100 * (i + 1) + 4);
      chk("drain_m_mispredict", m_mispredict, 0);
      tick;
    end
    chk("drain_empty", m_valid, 0);
    m_ready = 1'b0;

    // branch flush of ids 4 leaves only id 3
    for (int k = 0; k < 4; k++) begin
      drive(OP_BNE, 32'd1, 32'd2, 32'h500 + 32'(k * 4), 26'h0, 1'b1, 32'h0, ids[k], 1'b0, 8'h00);
      tick;
    end
    s_valid = 1'b0;
    flush_valid = 1'b1; flush_kind = 1'b1; flush_branch_id = 4'd4; m_ready = 1'b1;
    #1 chk("bflush_m_valid", m_valid, 1);
    chk("bflush_m_id", m_branch_id, 3);
    chk("bflush_fwd_valid", fwd_valid, 0);
    tick;
    flush_valid = 1'b0;
    chk("bflush_bubble1", m_valid, 0);
    tick;
    chk("bflush_bubble2", m_valid, 0);
    tick;
    m_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      drive(OP_BEQ, 32'd1, 32'd1, 32'h600, 26'h0, 1'b1, 32'h604, 4'd1, 1'b0, 8'h00);
      #1 chk("refill_s_ready", s_ready, 1);
      tick;
    end
    s_valid = 1'b0;
    #1 chk("refill_full", s_ready, 0);
    flush_valid = 1'b1; flush_kind = 1'b0;
    #1 chk("aflush_m_valid", m_valid, 0);
    chk("aflush_fwd_valid", fwd_valid, 0);
    tick;
    flush_valid = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      chk("aflush_no_valid", m_valid, 0);
      tick;
    end
    chk("aflush_s_ready", s_ready, 1);

    // delayslot entry survives a matching branch flush
    drive(OP_BEQ, 32'd1, 32'd1, 32'h700, 26'h0, 1'b1, 32'h704, 4'd4, 1'b1, 8'h00);
    tick;
    s_valid = 1'b0;
    flush_valid = 1'b1; flush_kind = 1'b1; flush_branch_id = 4'd4;
    #1 chk("ds_fwd_valid", fwd_valid, 1);
    tick;
    flush_valid = 1'b0;
    chk("ds_m_valid", m_valid, 1);
    chk("ds_m_ds", m_is_delayslot, 1);
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;

    // mispredicted BGTZ killed in stage by a full flush
    drive(OP_BGTZ, 32'h8000_0000, 32'h0, 32'h7000, 26'h2, 1'b1, 32'h700C, 4'd0, 1'b0, 8'h00);
    tick;
    s_valid = 1'b0;
    flush_valid = 1'b1; flush_kind = 1'b0;
    #1 chk("sflush_fwd_valid", fwd_valid, 0);
    tick;
    flush_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sflush_no_valid", m_valid, 0);
      tick;
    end

    // micro-op killed while being accepted
    drive(OP_JAL, 32'h0, 32'h0, 32'h800, 26'h1, 1'b1, 32'h4, 4'd0, 1'b0, 8'h00);
    flush_valid = 1'b1; flush_kind = 1'b0;
    tick;
    s_valid = 1'b0; flush_valid = 1'b0;
    #1 chk("accflush_fwd_valid", fwd_valid, 0);
    tick;
    chk("accflush_m_valid", m_valid, 0);

    // asynchronous reset with two queued entries
    drive(OP_BEQ, 32'd1, 32'd1, 32'h111, 26'h0, 1'b1, 32'h115, 4'd0, 1'b0, 8'h00);
    tick;
    drive(OP_BEQ, 32'd1, 32'd1, 32'h222, 26'h0, 1'b1, 32'h226, 4'd0, 1'b0, 8'h00);
    tick;
    s_valid = 1'b0;
    tick;
    chk("prerst_m_valid", m_valid, 1);
    #2 rst = 1'b0;
    #1 chk("midrst_m_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_m_pc", m_pc, 0);
    chk("midrst_fwd_valid", fwd_valid, 0);
    @(negedge clk) rst = 1'b1;
    tick;
    chk("postrst_m_valid", m_valid, 0);
    m_ready = 1'b1;
    drive(OP_BEQ, 32'd1, 32'd1, 32'h333, 26'h0, 1'b1, 32'h337, 4'd0, 1'b0, 8'h00);
    tick;
    s_valid = 1'b0;
    tick;
    chk("postrst_first_valid", m_valid, 1);
    chk("postrst_first_pc", m_pc, 32'h333);
    tick;
    chk("postrst_empty", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bru_q.md
Name: bru_q

Overview:
- Parametrised successor to the single-slot branch unit. Accepts branch/jump micro-ops from ISU and resolves them: target, taken, link value, rd_wen and the AdEL_IF exception bit.
- Adds checking against the front-end prediction and a DEPTH-entry in-order result queue toward WBU.
- Kills in-flight entries per entry on a WBU flush, and forwards the link value to ISU.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 2, result queue entries; power of two, ≥2.
- BID_W, 4, branch_id width.
- OP_W, 5, fu_op width; encodings are the FU_OP_BRU_* defines.
- RD_W, 5, destination register index width.
- ETW_W, 8, exception trace word width.
- ADEL_BIT, 0, ETW bit index that AdEL_IF sets.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  ISU micro-op valid
- s_ready  out  1  bru_q accepts micro-op
- s_op  in  OP_W  branch operation
- s_a, s_b  in  XLEN  rs/rt operands
- s_pc  in  XLEN  branch PC
- s_offset  in  26  instr_index / imm16 in [15:0]
- s_rd  in  RD_W  link register
- s_pred_taken  in  1  front-end predicted taken
- s_pred_target  in  XLEN  front-end predicted target
- s_is_delayslot  in  1
- s_branch_id  in  BID_W
- s_etw  in  ETW_W  incoming exception trace
- m_valid  out  1  result at queue head
- m_ready  in  1  WBU accepts
- m_target  out  XLEN
- m_taken  out  1
- m_mispredict  out  1
- m_val  out  XLEN  link value
- m_rd  out  RD_W
- m_rd_wen  out  1
- m_pc  out  XLEN
- m_is_delayslot  out  1
- m_branch_id  out  BID_W
- m_etw  out  ETW_W
- flush_valid  in  1
- flush_kind  in  1  0=ALL, 1=BRANCH
- flush_branch_id  in  BID_W
- fwd_valid  out  1
- fwd_val  out  XLEN
- fwd_rd  out  RD_W
- fwd_byte_wen  out  4

Behaviour:
- Reset (rst=0, asynchronous):
  - Stage register and all queue entry valid bits clear; pointers and count = 0.
  - Outputs: s_ready=1, m_valid=0, fwd_valid=0; all data outputs 0.
- Stage 0:
  - One register, loaded on s_valid&s_ready.
  - s_ready = !stg_v | enq, where enq = stg_v & !stg_kill & (count<DEPTH | (m_valid&m_ready)).
- Resolve (combinational on the stage register):
  - J/JAL: target={pc[31:28],offset,2'b00}.
  - JR/JALR/ERET: target=a.
  - All Bxx: target=pc+4+{sext(imm16),2'b00}, mod 2^XLEN.
  - taken: 1 for J/JAL/JR/JALR/ERET. BEQ a==b; BNE a!=b. BGEZ/BGEZAL, BGTZ, BLEZ, BLTZ/BLTZAL use signed compares against 0.
  - Undefined op: target=0, taken=0.
  - val=pc+8.
  - rd_wen=1 only for JAL/JALR/BGEZAL/BLTZAL.
  - mispredict = (taken!=pred_taken) | (taken & target!=pred_target).
  - etw_out = etw | (taken & target[1:0]!=0) << ADEL_BIT.
- Latency: s handshake at edge E0 -> enqueue at E1 if not blocked -> m_valid after E1. Throughput is 1/cycle when m_ready=1.
- Queue:
  - Circular buffer with wrap-around pointers.
  - Enqueue and dequeue in the same cycle are allowed at count==DEPTH; count is unchanged.
  - m_valid = head entry valid.
- Flush (per entry, evaluated at the clock edge while flush_valid=1):
  - Kill predicate: kind ALL kills every entry. Kind BRANCH kills entries with branch_id==flush_branch_id & !is_delayslot.
  - Applies to the stage register, every queue entry, and the micro-op being accepted that cycle.
  - Killed stage: stg_v cleared, not enqueued.
  - Killed queue entries: valid bit cleared, slot stays occupied as a bubble.
  - A head bubble is dropped automatically, one per cycle, with m_valid=0.
  - The head is not presented on a cycle it is killed: m_valid is masked by the kill predicate, so no handshake occurs.
- Forward:
  - fwd_valid=stg_v & !stg_kill.
  - fwd_val=val, fwd_rd=stg rd, fwd_byte_wen={4{rd_wen}}.
- Mid-operation reset clears everything within the same cycle; no partial result is emitted.

Test Plan:
- BEQ, a=b=5, pc=0x1000, imm=0x0003, pred_taken=1, pred_target=0x1010 -> m_target=0x1010, m_taken=1, m_mispredict=0, m_rd_wen=0, m_val=0x1008, m_valid two edges after the s handshake.
- JALR, a=0x2002, pred_taken=1, pred_target=0x2002 -> m_taken=1, ETW bit ADEL_BIT=1, m_rd_wen=1, fwd_byte_wen=4'hF while in stage.
- Hold m_ready=0 and push DEPTH+1 BNE ops -> after the queue fills and the stage holds one op, s_ready=0. Raise m_ready -> results appear in order, each cycle, across pointer wrap.
- Queue holds ids 3,4,4 (all non-delayslot) and the stage holds id 4; flush_kind=BRANCH, id=4 -> only id 3 is emitted; bubbles are dropped; count returns to 0 within 3 cycles.
- BGTZ, a=0x80000000 with pred_taken=1 -> m_taken=0, m_mispredict=1. flush_kind=ALL on the next cycle with m_ready=0 -> no m_valid ever.
- Assert rst=0 mid-stream with 2 entries queued -> m_valid=0 and s_ready=1 immediately. After release, the queue is empty.
